// File: rtl/fifo_pkg.sv
// fifo_pkg: shared types, defaults and helpers for the single-clock FIFO
// controller and its flag generator.
package fifo_pkg;

   // Power-on defaults for the programmable thresholds, in words.
   localparam int unsigned FIFO_AE_DEFAULT = 4;
   localparam int unsigned FIFO_AF_DEFAULT = 4;

   // Status flag bundle, produced combinationally and registered by the parent.
   typedef struct packed {
      logic empty;
      logic full;
      logic almst_empty;
      logic almst_full;
   } fifo_flags_t;

   // Flag values after reset or flush: nothing stored.
   localparam fifo_flags_t FIFO_FLAGS_RST = '{
      empty:       1'b1,
      full:        1'b0,
      almst_empty: 1'b1,
      almst_full:  1'b0
   };

   // Number of words addressed by an a_size-bit address.
   function automatic int unsigned fifo_depth(input int unsigned a_size);
      return 32'd1 << a_size;
   endfunction

endpackage

// File: rtl/fifo_flag_gen.sv
// fifo_flag_gen: combinational status-flag comparators. Takes the occupancy
// the FIFO will hold after this cycle and the live thresholds, and returns
// the flag bundle that the parent registers alongside the count.
module fifo_flag_gen
   import fifo_pkg::*;
#(
   parameter int unsigned A_SIZE = 12
) (
   input  logic [A_SIZE:0] i_count_nxt,
   input  logic [A_SIZE:0] i_ae_thresh,
   input  logic [A_SIZE:0] i_af_thresh,
   output fifo_flags_t     o_flags
);

   typedef logic [A_SIZE:0] cnt_t;

   localparam cnt_t DEPTH_W = cnt_t'(fifo_depth(A_SIZE));

   cnt_t free_nxt;

   // Compare next occupancy (and its complement) against the thresholds.
   // A threshold of 0 collapses the almost flags onto empty/full; a threshold
   // of DEPTH or more holds them high because occupancy never exceeds DEPTH.
   always_comb begin
      // NOTE: every output of a combinational block gets a value on every
      // path (here unconditionally), otherwise synthesis infers a latch.
      free_nxt            = DEPTH_W - i_count_nxt;
      o_flags.empty       = (i_count_nxt == '0);
      o_flags.full        = (i_count_nxt == DEPTH_W);
      o_flags.almst_empty = (i_count_nxt <= i_ae_thresh);
      o_flags.almst_full  = (free_nxt <= i_af_thresh);
   end

endmodule

// File: rtl/sync_fifo_ctrl_param.sv
// sync_fifo_ctrl_param: single-clock FIFO controller for an external simple
// dual-port RAM. Owns both pointers, the occupancy/free counts, the status
// flags, sticky error flags and a read-valid strobe aligned to RAM latency.
module sync_fifo_ctrl_param
   import fifo_pkg::*;
#(
   parameter int unsigned A_SIZE  = 12,
   parameter int unsigned RAM_LAT = 1
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_wr_en,
   input  logic              i_rd_en,
   input  logic              i_flush,
   input  logic              i_clr_err,
   input  logic [A_SIZE:0]   i_ae_thresh,
   input  logic [A_SIZE:0]   i_af_thresh,
   output logic              o_mem_we,
   output logic [A_SIZE-1:0] o_wr_addr,
   output logic [A_SIZE-1:0] o_rd_addr,
   output logic              o_mem_re,
   output logic              o_rd_valid,
   output logic [A_SIZE:0]   o_count,
   output logic [A_SIZE:0]   o_free,
   output logic              o_empty,
   output logic              o_full,
   output logic              o_almst_empty,
   output logic              o_almst_full,
   output logic              o_overflow,
   output logic              o_underflow
);

   // Pointers carry one extra wrap bit so they run modulo 2*DEPTH; counts
   // need the same width to represent the full value DEPTH.
   typedef logic [A_SIZE:0] ptr_t;

   localparam ptr_t DEPTH_W = ptr_t'(fifo_depth(A_SIZE));

   ptr_t               wr_ptr_q, wr_ptr_d;
   ptr_t               rd_ptr_q, rd_ptr_d;
   ptr_t               count_q, count_d;
   ptr_t               free_q, free_d;
   ptr_t               count_nxt;
   fifo_flags_t        flags_q, flags_d;
   fifo_flags_t        flags_nxt;
   logic               overflow_q, overflow_d;
   logic               underflow_q, underflow_d;
   logic [RAM_LAT-1:0] vld_q, vld_d;
   logic               wr_acc;
   logic               rd_acc;

   // Accept decisions use the registered flags only, so the RAM strobes are
   // a short AND path. A flush (or reset) cycle accepts nothing, keeping the
   // RAM untouched while the pointers are being cleared.
   always_comb begin
      wr_acc    = i_wr_en & ~flags_q.full  & ~i_flush & ~i_rst;
      rd_acc    = i_rd_en & ~flags_q.empty & ~i_flush & ~i_rst;
      count_nxt = count_q + ptr_t'(wr_acc) - ptr_t'(rd_acc);
   end

   // Flag comparators on the occupancy this cycle's traffic leaves behind.
   fifo_flag_gen #(
      .A_SIZE      (A_SIZE)
   ) u_flag_gen (
      .i_count_nxt (count_nxt),
      .i_ae_thresh (i_ae_thresh),
      .i_af_thresh (i_af_thresh),
      .o_flags     (flags_nxt)
   );

   // Next pointer, count, flag and read-valid pipeline state; flush
   // overrides traffic and returns everything to the just-reset picture.
   always_comb begin
      wr_ptr_d = wr_ptr_q + ptr_t'(wr_acc);
      rd_ptr_d = rd_ptr_q + ptr_t'(rd_acc);
      count_d  = count_nxt;
      free_d   = DEPTH_W - count_nxt;
      flags_d  = flags_nxt;
      vld_d    = '0;
      vld_d[0] = rd_acc;
      for (int i = 1; i < int'(RAM_LAT); i++) begin
         vld_d[i] = vld_q[i-1];
      end
      if (i_flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
         free_d   = DEPTH_W;
         flags_d  = FIFO_FLAGS_RST;
         vld_d    = '0;
      end
   end

   // Sticky error flags: a new error in the same cycle as a clear wins.
   // Requests in a flush cycle are discarded, so they cannot flag an error.
   always_comb begin
      overflow_d  = overflow_q  & ~i_clr_err;
      underflow_d = underflow_q & ~i_clr_err;
      if (!i_flush) begin
         if (i_wr_en & flags_q.full) begin
            overflow_d = 1'b1;
         end
         if (i_rd_en & flags_q.empty) begin
            underflow_d = 1'b1;
         end
      end
   end

   // State registers with synchronous reset; reset drops all contents and
   // any read still travelling through the valid pipeline.
   always_ff @(posedge i_clk) begin
      // NOTE: sequential state is assigned with <= so every flop samples the
      // values from before this edge, independent of statement order.
      if (i_rst) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         free_q      <= DEPTH_W;
         flags_q     <= FIFO_FLAGS_RST;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
         vld_q       <= '0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         free_q      <= free_d;
         flags_q     <= flags_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
         vld_q       <= vld_d;
      end
   end

   // RAM side: strobes are the accept terms, addresses the current pointers.
   assign o_mem_we   = wr_acc;
   assign o_mem_re   = rd_acc;
   assign o_wr_addr  = wr_ptr_q[A_SIZE-1:0];
   assign o_rd_addr  = rd_ptr_q[A_SIZE-1:0];
   assign o_rd_valid = vld_q[RAM_LAT-1];

   // Registered status.
   assign o_count       = count_q;
   assign o_free        = free_q;
   assign o_empty       = flags_q.empty;
   assign o_full        = flags_q.full;
   assign o_almst_empty = flags_q.almst_empty;
   assign o_almst_full  = flags_q.almst_full;
   assign o_overflow    = overflow_q;
   assign o_underflow   = underflow_q;

endmodule

// File: tb/tb_sync_fifo_ctrl_param.sv
// tb_sync_fifo_ctrl_param: directed plus random stimulus for an 8-deep FIFO
// controller. Two instances share the inputs, one with a 1-cycle and one
// with a 2-cycle RAM latency; both are compared against an occupancy model.
module tb_sync_fifo_ctrl_param;
   import fifo_pkg::*;

   localparam int unsigned A     = 3;
   localparam int          DEPTH = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst, wr_en, rd_en, flush, clr_err;
   logic [A:0]   ae_th, af_th;

   logic         mem_we1, mem_re1, rd_valid1, empty1, full1, ae1, af1, ovf1, udf1;
   logic [A-1:0] wa1, ra1;
   logic [A:0]   cnt1, free1;
   logic         mem_we2, mem_re2, rd_valid2, empty2, full2, ae2, af2, ovf2, udf2;
   logic [A-1:0] wa2, ra2;
   logic [A:0]   cnt2, free2;

   sync_fifo_ctrl_param #(.A_SIZE(A), .RAM_LAT(1)) u_dut1 (
      .i_clk(clk), .i_rst(rst), .i_wr_en(wr_en), .i_rd_en(rd_en),
      .i_flush(flush), .i_clr_err(clr_err), .i_ae_thresh(ae_th), .i_af_thresh(af_th),
      .o_mem_we(mem_we1), .o_wr_addr(wa1), .o_rd_addr(ra1), .o_mem_re(mem_re1),
      .o_rd_valid(rd_valid1), .o_count(cnt1), .o_free(free1), .o_empty(empty1),
      .o_full(full1), .o_almst_empty(ae1), .o_almst_full(af1),
      .o_overflow(ovf1), .o_underflow(udf1)
   );

   sync_fifo_ctrl_param #(.A_SIZE(A), .RAM_LAT(2)) u_dut2 (
      .i_clk(clk), .i_rst(rst), .i_wr_en(wr_en), .i_rd_en(rd_en),
      .i_flush(flush), .i_clr_err(clr_err), .i_ae_thresh(ae_th), .i_af_thresh(af_th),
      .o_mem_we(mem_we2), .o_wr_addr(wa2), .o_rd_addr(ra2), .o_mem_re(mem_re2),
      .o_rd_valid(rd_valid2), .o_count(cnt2), .o_free(free2), .o_empty(empty2),
      .o_full(full2), .o_almst_empty(ae2), .o_almst_full(af2),
      .o_overflow(ovf2), .o_underflow(udf2)
   );

   // Reference model: words stored, running pointers, registered flag state
   // and the history of accepted reads for the two latencies.
   int m_count, m_wp, m_rp;
   bit m_ae, m_af, m_ovf, m_udf, m_h1, m_h2, m_valid;
   int n_assert = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // RAM strobes and addresses for the inputs currently applied.
   task automatic comb_checks();
      bit wa, ra;
      wa = wr_en && !rst && !flush && (m_count != DEPTH);
      ra = rd_en && !rst && !flush && (m_count != 0);
      check("mem_we", mem_we1, wa);
      check("mem_re", mem_re1, ra);
      check("wr_addr", wa1, m_wp % DEPTH);
      check("rd_addr", ra1, m_rp % DEPTH);
      check("mem_re_lat2", mem_re2, ra);
      check("wr_addr_lat2", wa2, m_wp % DEPTH);
   endtask

   // Advance the model by one clock edge using the applied inputs.
   task automatic model_edge();
      bit wa, ra;
      if (rst) begin
         m_count = 0; m_wp = 0; m_rp = 0;
         m_ae = 1'b1; m_af = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;
         m_h1 = 1'b0; m_h2 = 1'b0; m_valid = 1'b1;
      end else if (flush) begin
         m_count = 0; m_wp = 0; m_rp = 0;
         m_ae = 1'b1; m_af = 1'b0;
         m_ovf = m_ovf && !clr_err;
         m_udf = m_udf && !clr_err;
         m_h1 = 1'b0; m_h2 = 1'b0;
      end else begin
         wa = wr_en && (m_count != DEPTH);
         ra = rd_en && (m_count != 0);
         m_ovf   = (wr_en && m_count == DEPTH) || (m_ovf && !clr_err);
         m_udf   = (rd_en && m_count == 0) || (m_udf && !clr_err);
         m_count = m_count + int'(wa) - int'(ra);
         m_wp    = (m_wp + int'(wa)) % (2 * DEPTH);
         m_rp    = (m_rp + int'(ra)) % (2 * DEPTH);
         m_ae    = (m_count <= int'(ae_th));
         m_af    = ((DEPTH - m_count) <= int'(af_th));
         m_h2    = m_h1;
         m_h1    = ra;
      end
   endtask

   task automatic reg_checks();
      check("count", cnt1, m_count);
      check("free", free1, DEPTH - m_count);
      check("empty", empty1, m_count == 0);
      check("full", full1, m_count == DEPTH);
      check("almst_empty", ae1, m_ae);
      check("almst_full", af1, m_af);
      check("overflow", ovf1, m_ovf);
      check("underflow", udf1, m_udf);
      check("rd_valid", rd_valid1, m_h1);
      check("rd_valid_lat2", rd_valid2, m_h2);
      check("count_lat2", cnt2, m_count);
   endtask

   // One clock: check strobes, take the edge, check registered outputs.
   task automatic cycle();
      #1;
      if (m_valid) comb_checks();
      @(posedge clk);
      model_edge();
      #1;
      if (m_valid) reg_checks();
   endtask

   task automatic run(input int n, input logic w, input logic r);
      wr_en = w;
      rd_en = r;
      for (int i = 0; i < n; i++) cycle();
      wr_en = 1'b0;
      rd_en = 1'b0;
   endtask

   initial begin
      rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0; clr_err = 1'b0;
      ae_th = 4'(FIFO_AE_DEFAULT);
      af_th = 4'(FIFO_AF_DEFAULT);
      m_valid = 1'b0;

      // Reset state.
      cycle();
      cycle();
      rst = 1'b0;
      check("reset_empty", empty1, 1);
      check("reset_free", free1, DEPTH);

      // Fill with 8 writes, then drain with 8 reads.
      run(8, 1'b1, 1'b0);
      check("fill_full", full1, 1);
      check("fill_count", cnt1, 8);
      run(8, 1'b0, 1'b1);
      check("drain_empty", empty1, 1);
      cycle();
      check("drain_valid_done", rd_valid1, 0);

      // Thresholds ae=2, af=1: fill to 7, then raise ae with no traffic.
      ae_th = 4'd2;
      af_th = 4'd1;
      cycle();
      run(3, 1'b1, 1'b0);
      check("ae_off_at_3", ae1, 0);
      run(4, 1'b1, 1'b0);
      check("af_on_at_7", af1, 1);
      ae_th = 4'd7;
      cycle();
      check("ae_thresh_change", ae1, 1);

      // Simultaneous traffic at count 4, wrapping the pointers.
      run(3, 1'b0, 1'b1);
      run(20, 1'b1, 1'b1);
      check("rw_count_held", cnt1, 4);
      run(4, 1'b0, 1'b1);
      run(1, 1'b1, 1'b1);
      check("rw_empty_write_only", cnt1, 1);

      // Errors: write when full, read when empty, then clear.
      run(7, 1'b1, 1'b0);
      run(1, 1'b1, 1'b0);
      check("overflow_set", ovf1, 1);
      run(8, 1'b0, 1'b1);
      run(1, 1'b0, 1'b1);
      check("underflow_set", udf1, 1);
      run(2, 1'b0, 1'b0);
      clr_err = 1'b1;
      cycle();
      clr_err = 1'b0;
      check("err_cleared", ovf1 | udf1, 0);

      // Flush at count 5 with a read in flight; requests ignored.
      run(6, 1'b1, 1'b0);
      run(1, 1'b0, 1'b1);
      flush = 1'b1; wr_en = 1'b1; rd_en = 1'b1;
      cycle();
      flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
      check("flush_count", cnt1, 0);
      check("flush_squash_lat2", rd_valid2, 0);

      // Flush while full with a write request raises no overflow.
      run(8, 1'b1, 1'b0);
      flush = 1'b1; wr_en = 1'b1;
      cycle();
      flush = 1'b0; wr_en = 1'b0;
      check("flush_no_ovf", ovf1, 0);

      // Mid-fill reset after an underflow.
      run(1, 1'b0, 1'b1);
      run(3, 1'b1, 1'b0);
      rst = 1'b1; wr_en = 1'b1;
      cycle();
      rst = 1'b0; wr_en = 1'b0;
      check("rst_udf_cleared", udf1, 0);
      check("rst_count", cnt1, 0);

      // Random traffic, thresholds, flushes, clears and rare resets.
      for (int i = 0; i < 600; i++) begin
         wr_en   = ($urandom_range(0, 99) < 55);
         rd_en   = ($urandom_range(0, 99) < 50);
         flush   = ($urandom_range(0, 39) == 0);
         clr_err = ($urandom_range(0, 19) == 0);
         rst     = ($urandom_range(0, 199) == 0);
         if ($urandom_range(0, 15) == 0) ae_th = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 15) == 0) af_th = 4'($urandom_range(0, 15));
         cycle();
      end
      rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0; clr_err = 1'b0;
      cycle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/sync_fifo_ctrl_param.md
Name: sync_fifo_ctrl_param

Overview:
Single-clock FIFO controller that owns the write and read pointers, occupancy accounting and all status flags for an external simple dual-port block RAM. It replaces the per-domain pointer/empty logic wherever both FIFO sides share one clock, for example UART-to-DDR3 staging buffers. Relative to the previous generation it adds:
- runtime-programmable almost-empty and almost-full thresholds
- exact occupancy and free-space counts
- synchronous flush
- sticky overflow/underflow error flags
- a read-data-valid strobe matched to the RAM latency

Parameters:
A_SIZE, 12, address width; DEPTH = 2**A_SIZE words
RAM_LAT, 1, read latency of the external RAM in cycles (1 or 2)

Ports:
i_clk  in  1  clock
i_rst  in  1  reset, synchronous, active-high
i_wr_en  in  1  write request
i_rd_en  in  1  read request
i_flush  in  1  synchronous clear of pointers and count
i_clr_err  in  1  clears the sticky error flags
i_ae_thresh  in  A_SIZE+1  almost-empty threshold
i_af_thresh  in  A_SIZE+1  almost-full threshold, measured as free words
o_mem_we  out  1  RAM write enable
o_wr_addr  out  A_SIZE  RAM write address
o_rd_addr  out  A_SIZE  RAM read address
o_mem_re  out  1  RAM read enable
o_rd_valid  out  1  RAM read data valid
o_count  out  A_SIZE+1  words stored, 0..DEPTH
o_free  out  A_SIZE+1  DEPTH - o_count
o_empty, o_full, o_almst_empty, o_almst_full  out  1 each  status flags
o_overflow, o_underflow  out  1 each  sticky error flags

Behaviour:
- Clock and reset: one clock, i_clk. Reset is synchronous and active-high on i_rst.
- Reset values: wr_ptr=0, rd_ptr=0, count=0, o_empty=1, o_full=0, o_almst_empty=1, o_almst_full=0, o_overflow=0, o_underflow=0, o_rd_valid pipeline=0.
- Reset mid-operation discards all contents. Any in-flight o_rd_valid is squashed.
- Pointers: wr_ptr and rd_ptr are A_SIZE+1 bits wide and wrap modulo 2*DEPTH. Addresses are ptr[A_SIZE-1:0].
- Accept conditions: wr_acc = i_wr_en & ~o_full; rd_acc = i_rd_en & ~o_empty. Both use the registered flags.
- Memory outputs: o_mem_we = wr_acc and o_mem_re = rd_acc, both combinational. Addresses show the current pointers.
- Pointer update: on accept, the pointer increments at the next edge.
- Count update: count_nxt = count + wr_acc - rd_acc. Simultaneous wr_acc and rd_acc leave the count unchanged.
- When empty with both requests: only the write is accepted.
- When full with both requests: only the read is accepted. There is no write-through-on-full.
- Flags are registered and computed from count_nxt and the current thresholds:
  - empty = (count_nxt==0)
  - full = (count_nxt==DEPTH)
  - almst_empty = (count_nxt <= i_ae_thresh)
  - almst_full = (DEPTH - count_nxt <= i_af_thresh)
- Flags and o_count are coherent every cycle. A threshold change is reflected 1 cycle later, even with no traffic.
- Edge thresholds: thresh=0 makes almst_empty equal empty, and almst_full equal full. Thresholds >= DEPTH force the flag permanently high.
- o_rd_valid: equals rd_acc delayed RAM_LAT cycles through a shift register.
- Flush: i_flush (priority below i_rst, above traffic) zeroes the pointers and count, sets flags as after reset, and squashes the o_rd_valid pipeline. Requests in the flush cycle are ignored and do not raise error flags. Error flags are untouched by flush.
- Error flags:
  - o_overflow sets on i_wr_en & o_full.
  - o_underflow sets on i_rd_en & o_empty.
  - Both hold until i_clr_err or i_rst.
  - If set and clear occur in the same cycle, set wins.
- o_free is registered alongside o_count. It never underflows.

Decomposition:
- Shared package fifo_pkg:
  - function fifo_depth(A_SIZE)
  - localparam default thresholds (AE=4, AF=4)
  - packed flag-bundle type {empty, full, almst_empty, almst_full}
- One natural sub-module, fifo_flag_gen: combinational count_nxt/threshold comparators producing the flag bundle, registered in the parent. All pointer, count, error and valid-pipeline logic stays in sync_fifo_ctrl_param.

Test Plan:
- Reset, then 8 writes with A_SIZE=3 -> o_count steps 1..8, o_full=1 after the 8th edge, o_wr_addr sequence 0..7, o_empty low after the 1st edge.
- Full FIFO, then 8 reads (RAM_LAT=1) -> o_rd_addr 0..7, o_rd_valid high exactly 1 cycle after each o_mem_re, o_empty=1 after the 8th.
- Ae=2, af=1, fill to 7 -> almst_empty deasserts at count 3, almst_full asserts at count 7. Change ae to 7 with no traffic -> almst_empty=1 next cycle.
- Simultaneous wr/rd at count 4 for 20 cycles -> count stays 4, pointers wrap past 15 to 0 with correct addresses. Simultaneous wr/rd when empty -> count becomes 1, no read.
- Write when full and read when empty -> o_overflow and o_underflow set and sticky, count unchanged. i_clr_err -> both clear next cycle.
- Flush at count 5 with a read in flight -> count 0, o_empty=1, o_rd_valid squashed. Mid-fill i_rst -> same, plus error flags cleared.
